lane_frame_sequencer: RTL and testbench

Frame-level controller between the Sobel edge stream and the lane decision datapath. It aligns the decision block to frame boundaries using an explicit start-of-frame marker and forwards only complete, aligned frames. On misalignment or a missing result it resynchronises the decision block through a dedicated local reset. Each frame's lane result is captured into a one-entry valid/ready buffer that feeds the speed control unit.

---
 rtl/lane_pkg.sv | 43 ++++
 rtl/counter.sv | 47 ++++
 rtl/lane_result_buffer.sv | 60 ++++++
 rtl/lane_frame_sequencer.sv | 250 +++++++++++++++++++++++++
 tb/tb_lane_frame_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lane_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lane_pkg
//  Brief    : Shared types for the lane frame sequencer: FSM state encoding,
//             the buffered lane result record and small sizing helpers.
//  Revision : 1.0 - initial release
// ============================================================================
package lane_pkg;

  // Boundary fields are stored at a fixed width so the record type does not
  // depend on the image width; the top truncates back to its own BW.
  localparam int c_pos_w = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    RESYNC = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0]         num_lanes;
    logic [3:0]         cur_lane;
    logic [c_pos_w-1:0] left;
    logic [c_pos_w-1:0] right;
    logic [7:0]         frame_id;
  } lane_result_t;

  // Empty buffer contents; id 0xFF makes the first captured result id 0.
  localparam lane_result_t c_result_reset = '{
    num_lanes : 4'd0,
    cur_lane  : 4'd0,
    left      : '0,
    right     : '0,
    frame_id  : 8'hFF
  };

  // Bits needed to hold values 0..max_count (at least one bit).
  function automatic int cnt_width(input int max_count);
    return (max_count < 2) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/counter.sv
`default_nettype none
// ============================================================================
//  Module   : counter
//  Brief    : Wrapping up-counter 0..MAX_COUNT with synchronous clear.
//             Clear has priority over increment.
//  Revision : 1.0 - initial release
// ============================================================================
module counter #(
  parameter int MAX_COUNT = 7,
  parameter int WIDTH     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             at_max;

  assign at_max = (count_q == WIDTH'(MAX_COUNT));

  // Next count: clear, wrap at MAX_COUNT, or step by one.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = at_max ? '0 : count_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/lane_result_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : lane_result_buffer
//  Brief    : One-entry valid/ready result register. A capture into a full,
//             stalled entry overwrites it and bumps a saturating drop count;
//             capture and consume in the same cycle just reloads the entry.
//  Revision : 1.0 - initial release
// ============================================================================
module lane_result_buffer
  import lane_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cap_valid,
  input  lane_result_t cap_data,
  input  logic         res_ready,
  output logic         res_valid,
  output lane_result_t res_data,
  output logic [7:0]   drop_cnt
);

  logic         valid_q, valid_d;
  lane_result_t data_q,  data_d;
  logic [7:0]   drop_q,  drop_d;

  // Entry update: capture wins over consume; overwrite of a stalled entry counts a drop.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    drop_d  = drop_q;
    if (cap_valid) begin
      valid_d = 1'b1;
      data_d  = cap_data;
      if (valid_q && !res_ready && (drop_q != 8'hFF)) begin
        drop_d = drop_q + 8'd1;
      end
    end else if (valid_q && res_ready) begin
      valid_d = 1'b0;
    end
  end

  // Entry registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= c_result_reset;
      drop_q  <= 8'd0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
    end
  end

  assign res_valid = valid_q;
  assign res_data  = data_q;
  assign drop_cnt  = drop_q;

endmodule
`default_nettype wire

// File: rtl/lane_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : lane_frame_sequencer
//  Brief    : Aligns the lane decision block to frame boundaries, forwards
//             complete frames, resynchronises the block on misalignment or a
//             missing result, and buffers each frame's lane result.
//  Revision : 1.0 - initial release
// ============================================================================
module lane_frame_sequencer
  import lane_pkg::*;
#(
  parameter  int IMG_WIDTH      = 640,
  parameter  int IMG_LENGTH     = 640,
  parameter  int RESULT_TIMEOUT = 8,
  parameter  int RESYNC_CYCLES  = 2,
  localparam int BW             = $clog2(IMG_WIDTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          pix_valid,
  input  logic          pix_sof,
  input  logic          pix_th1,
  input  logic          pix_th2,
  output logic          dec_rst_n,
  output logic          dec_valid,
  output logic          dec_th1,
  output logic          dec_th2,
  input  logic          dec_out_valid,
  input  logic [3:0]    dec_num_lanes,
  input  logic [3:0]    dec_cur_lane,
  input  logic [BW-1:0] dec_left,
  input  logic [BW-1:0] dec_right,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [3:0]    res_num_lanes,
  output logic [3:0]    res_cur_lane,
  output logic [BW-1:0] res_left,
  output logic [BW-1:0] res_right,
  output logic [7:0]    res_frame_id,
  output logic          frame_err,
  output logic [7:0]    drop_cnt,
  output logic          busy
);

  localparam int COL_W = cnt_width(IMG_WIDTH - 1);
  localparam int ROW_W = cnt_width(IMG_LENGTH - 1);
  localparam int TMO_W = cnt_width(RESULT_TIMEOUT - 1);
  localparam int RSY_W = cnt_width(RESYNC_CYCLES - 1);

  state_e           state_q, state_d;
  logic [RSY_W-1:0] rsy_cnt_q, rsy_cnt_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             pending_q, pending_d;
  logic             dec_valid_q, dec_valid_d;
  logic             dec_th1_q, dec_th1_d;
  logic             dec_th2_q, dec_th2_d;
  logic             dec_rst_n_q, dec_rst_n_d;
  logic             frame_err_q, frame_err_d;

  logic             fwd;
  logic             last_pix;
  logic             early_sof;
  logic             enter_resync;
  logic             capture;
  logic             stray;
  logic             timeout;

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             col_last;
  logic             row_last;

  lane_result_t     cap_data;
  lane_result_t     buf_data;
  logic             unused_pos_hi;

  // Result tracking is independent of the FSM: a result is only accepted
  // while a completed frame is waiting for it.
  assign capture  = dec_out_valid & pending_q;
  assign stray    = dec_out_valid & ~pending_q;
  // A result arriving in the final window cycle still counts as on time.
  assign timeout  = pending_q & ~dec_out_valid & (tmo_cnt_q == '0);

  assign col_last = (col == COL_W'(IMG_WIDTH - 1));
  assign row_last = (row == ROW_W'(IMG_LENGTH - 1));

  // Column position within the frame; the sof pixel advances it to 1.
  counter #(
    .MAX_COUNT (IMG_WIDTH - 1),
    .WIDTH     (COL_W)
  ) u_col_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (enter_resync),
    .inc   (fwd),
    .count (col)
  );

  // Row position; advances when the column wraps.
  counter #(
    .MAX_COUNT (IMG_LENGTH - 1),
    .WIDTH     (ROW_W)
  ) u_row_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (enter_resync),
    .inc   (fwd & col_last),
    .count (row)
  );

  // Frame alignment FSM: selects forwarded pixels and decides when to resync.
  always_comb begin
    state_d      = state_q;
    rsy_cnt_d    = rsy_cnt_q;
    fwd          = 1'b0;
    last_pix     = 1'b0;
    early_sof    = 1'b0;
    enter_resync = 1'b0;
    case (state_q)
      IDLE: begin
        if (pix_valid && pix_sof && enable) begin
          fwd     = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (pix_valid) begin
          if (pix_sof) begin
            early_sof = 1'b1;
            state_d   = RESYNC;
          end else begin
            fwd = 1'b1;
            if (col_last && row_last) begin
              last_pix = 1'b1;
              state_d  = IDLE;
            end
          end
        end
      end
      RESYNC: begin
        if (rsy_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          rsy_cnt_d = rsy_cnt_q - RSY_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // A missing result abandons any in-flight frame and drops a coincident sof.
    if (timeout) begin
      fwd      = 1'b0;
      last_pix = 1'b0;
      state_d  = RESYNC;
    end
    enter_resync = (state_d == RESYNC) && (state_q != RESYNC);
    if (enter_resync) begin
      rsy_cnt_d = RSY_W'(RESYNC_CYCLES - 1);
    end
  end

  // Pending/timeout tracking and next values of the registered outputs.
  always_comb begin
    pending_d = pending_q;
    tmo_cnt_d = tmo_cnt_q;
    if (state_d == RESYNC) begin
      pending_d = 1'b0;
    end else if (last_pix) begin
      pending_d = 1'b1;
    end else if (capture) begin
      pending_d = 1'b0;
    end
    if (last_pix) begin
      tmo_cnt_d = TMO_W'(RESULT_TIMEOUT - 1);
    end else if (pending_q && (tmo_cnt_q != '0)) begin
      tmo_cnt_d = tmo_cnt_q - TMO_W'(1);
    end
    dec_valid_d = fwd;
    dec_th1_d   = fwd & pix_th1;
    dec_th2_d   = fwd & pix_th2;
    dec_rst_n_d = (state_d != RESYNC);
    frame_err_d = early_sof | stray | timeout;
  end

  // Control and output registers; dec_rst_n is held low while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rsy_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      pending_q   <= 1'b0;
      dec_valid_q <= 1'b0;
      dec_th1_q   <= 1'b0;
      dec_th2_q   <= 1'b0;
      dec_rst_n_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsy_cnt_q   <= rsy_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      pending_q   <= pending_d;
      dec_valid_q <= dec_valid_d;
      dec_th1_q   <= dec_th1_d;
      dec_th2_q   <= dec_th2_d;
      dec_rst_n_q <= dec_rst_n_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Assemble the captured record; the id follows the last buffered one.
  always_comb begin
    cap_data           = c_result_reset;
    cap_data.num_lanes = dec_num_lanes;
    cap_data.cur_lane  = dec_cur_lane;
    cap_data.left      = c_pos_w'(dec_left);
    cap_data.right     = c_pos_w'(dec_right);
    cap_data.frame_id  = buf_data.frame_id + 8'd1;
  end

  lane_result_buffer u_result_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .cap_valid (capture),
    .cap_data  (cap_data),
    .res_ready (res_ready),
    .res_valid (res_valid),
    .res_data  (buf_data),
    .drop_cnt  (drop_cnt)
  );

  // Upper boundary bits are always zero; they only exist in the shared record.
  assign unused_pos_hi = |{buf_data.left >> BW, buf_data.right >> BW};

  assign res_num_lanes = buf_data.num_lanes;
  assign res_cur_lane  = buf_data.cur_lane;
  assign res_left      = BW'(buf_data.left);
  assign res_right     = BW'(buf_data.right);
  assign res_frame_id  = buf_data.frame_id;

  assign dec_rst_n = dec_rst_n_q;
  assign dec_valid = dec_valid_q;
  assign dec_th1   = dec_th1_q;
  assign dec_th2   = dec_th2_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE) | pending_q;

endmodule
`default_nettype wire

// File: tb/tb_lane_frame_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_lane_frame_sequencer
//  Brief    : Scoreboard bench for lane_frame_sequencer on an 8x4 frame.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lane_frame_sequencer;

  localparam int W     = 8;
  localparam int L     = 4;
  localparam int TO    = 8;
  localparam int RC    = 2;
  localparam int BW    = $clog2(W) + 1;
  localparam int NPIX  = W * L;
  localparam int RES_W = 16 + 2 * BW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          pix_valid = 1'b0;
  logic          pix_sof = 1'b0;
  logic          pix_th1 = 1'b0;
  logic          pix_th2 = 1'b0;
  logic          dec_rst_n;
  logic          dec_valid;
  logic          dec_th1;
  logic          dec_th2;
  logic          dec_out_valid = 1'b0;
  logic [3:0]    dec_num_lanes = 4'd0;
  logic [3:0]    dec_cur_lane = 4'd0;
  logic [BW-1:0] dec_left = '0;
  logic [BW-1:0] dec_right = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [3:0]    res_num_lanes;
  logic [3:0]    res_cur_lane;
  logic [BW-1:0] res_left;
  logic [BW-1:0] res_right;
  logic [7:0]    res_frame_id;
  logic          frame_err;
  logic [7:0]    drop_cnt;
  logic          busy;

  lane_frame_sequencer #(
    .IMG_WIDTH      (W),
    .IMG_LENGTH     (L),
    .RESULT_TIMEOUT (TO),
    .RESYNC_CYCLES  (RC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .pix_valid     (pix_valid),
    .pix_sof       (pix_sof),
    .pix_th1       (pix_th1),
    .pix_th2       (pix_th2),
    .dec_rst_n     (dec_rst_n),
    .dec_valid     (dec_valid),
    .dec_th1       (dec_th1),
    .dec_th2       (dec_th2),
    .dec_out_valid (dec_out_valid),
    .dec_num_lanes (dec_num_lanes),
    .dec_cur_lane  (dec_cur_lane),
    .dec_left      (dec_left),
    .dec_right     (dec_right),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_num_lanes (res_num_lanes),
    .res_cur_lane  (res_cur_lane),
    .res_left      (res_left),
    .res_right     (res_right),
    .res_frame_id  (res_frame_id),
    .frame_err     (frame_err),
    .drop_cnt      (drop_cnt),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0]       exp_pix_q[$];
  logic [RES_W-1:0] exp_res_q[$];
  logic [7:0]       exp_id     = 8'hFF;
  int               model_drop = 0;
  int               err_seen   = 0;
  int               rst_low    = 0;
  int               pix_seen   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor, run once per cycle at the falling edge.
  task automatic sample();
    if (!rst_n) return;
    if (dec_valid) begin
      pix_seen++;
      if (exp_pix_q.size() == 0) check("pix_unexpected", 1, 0);
      else check("pix_data", {dec_th1, dec_th2}, exp_pix_q.pop_front());
    end
    if (frame_err) err_seen++;
    if (!dec_rst_n) rst_low++;
    if (res_valid && res_ready) begin
      if (exp_res_q.size() == 0) check("res_unexpected", 1, 0);
      else check("res_entry", {res_num_lanes, res_cur_lane, res_left, res_right, res_frame_id},
                 exp_res_q.pop_front());
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard entry for a result the DUT is expected to capture.
  task automatic push_result(input logic [3:0] nl, input logic [3:0] cl,
                             input logic [BW-1:0] l, input logic [BW-1:0] r);
    exp_id = exp_id + 8'd1;
    if (!res_ready && exp_res_q.size() != 0) begin
      void'(exp_res_q.pop_back());
      if (model_drop < 255) model_drop++;
    end
    exp_res_q.push_back({nl, cl, l, r, exp_id});
  endtask

  task automatic set_result(input logic [3:0] nl, input logic [3:0] cl,
                            input logic [BW-1:0] l, input logic [BW-1:0] r, input bit expect_cap);
    dec_out_valid = 1'b1;
    dec_num_lanes = nl;
    dec_cur_lane  = cl;
    dec_left      = l;
    dec_right     = r;
    if (expect_cap) push_result(nl, cl, l, r);
  endtask

  // One-cycle result strobe.
  task automatic pulse_result(input logic [3:0] nl, input logic [3:0] cl,
                              input logic [BW-1:0] l, input logic [BW-1:0] r, input bit expect_cap);
    set_result(nl, cl, l, r, expect_cap);
    tick();
    dec_out_valid = 1'b0;
  endtask

  // Streams n pixels with sof on pixel 0 (and on early_at if >= 0).
  // res_at >= 0 strobes a result (4,2,1,5) alongside that pixel.
  // en_off_at >= 0 drops enable at that pixel.
  task automatic send_frame(input int n, input int early_at, input int res_at,
                            input bit fwd, input int en_off_at);
    for (int i = 0; i < n; i++) begin
      logic [1:0] th;
      th        = 2'($urandom_range(0, 3));
      pix_valid = 1'b1;
      pix_sof   = (i == 0) || (i == early_at);
      pix_th1   = th[1];
      pix_th2   = th[0];
      if (i == en_off_at) enable = 1'b0;
      if (i == res_at) set_result(4'd4, 4'd2, BW'(1), BW'(5), 1'b1);
      if (fwd && (early_at < 0 || i < early_at)) exp_pix_q.push_back(th);
      tick();
      dec_out_valid = 1'b0;
    end
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int err0;
    int low0;
    int pix0;
    res_ready = 1'b1;
    enable    = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset values
    check("rst_dec_rst_n", dec_rst_n, 0);
    check("rst_dec_valid", dec_valid, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_frame_id", res_frame_id, 8'hFF);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_res_data", {res_num_lanes, res_cur_lane, res_left, res_right}, 0);
    rst_n = 1'b1;
    tick();
    check("rel_dec_rst_n", dec_rst_n, 1);

    // Clean frame
    err0 = err_seen; pix0 = pix_seen;
    send_frame(NPIX, -1, -1, 1, -1);
    check("clean_busy_pending", busy, 1);
    tick();
    pulse_result(4'd3, 4'd1, BW'(2), BW'(6), 1'b1);
    check("clean_res_valid", res_valid, 1);
    check("clean_id", res_frame_id, 8'd0);
    check("clean_num_lanes", res_num_lanes, 4'd3);
    check("clean_left", res_left, BW'(2));
    check("clean_right", res_right, BW'(6));
    tick();
    check("clean_consumed", res_valid, 0);
    check("clean_not_busy", busy, 0);
    repeat (2) tick();
    check("clean_pix_count", pix_seen - pix0, NPIX);
    check("clean_no_err", err_seen - err0, 0);
    check("clean_res_q", exp_res_q.size(), 0);

    // Early sof
    err0 = err_seen; low0 = rst_low; pix0 = pix_seen;
    send_frame(NPIX, 10, -1, 1, -1);
    repeat (3) tick();
    check("esof_err", err_seen - err0, 1);
    check("esof_rst_low", rst_low - low0, RC);
    check("esof_pix_count", pix_seen - pix0, 10);
    check("esof_pix_q", exp_pix_q.size(), 0);

    // Timeout
    send_frame(NPIX, -1, -1, 1, -1);
    repeat (7) tick();
    check("tmo_err_early", frame_err, 0);
    tick();
    check("tmo_err", frame_err, 1);
    check("tmo_rst_low0", dec_rst_n, 0);
    check("tmo_busy", busy, 1);
    tick();
    check("tmo_rst_low1", dec_rst_n, 0);
    check("tmo_err_pulse", frame_err, 0);
    tick();
    check("tmo_rst_release", dec_rst_n, 1);
    check("tmo_no_result", res_valid, 0);

    // Stray result with nothing pending
    tick();
    pulse_result(4'd1, 4'd1, BW'(1), BW'(1), 1'b0);
    check("stray_err", frame_err, 1);
    tick();
    check("stray_no_result", res_valid, 0);

    // Overwrite with consumer stalled
    res_ready = 1'b0;
    send_frame(NPIX, -1, -1, 1, -1);
    tick();
    pulse_result(4'd5, 4'd2, BW'(1), BW'(7), 1'b1);
    send_frame(NPIX, -1, -1, 1, -1);
    tick();
    pulse_result(4'd2, 4'd0, BW'(3), BW'(4), 1'b1);
    check("ovw_id", res_frame_id, exp_id);
    check("ovw_num_lanes", res_num_lanes, 4'd2);
    check("ovw_left", res_left, BW'(3));
    check("ovw_drop1", drop_cnt, 8'd1);
    for (int k = 0; k < 256; k++) begin
      send_frame(NPIX, -1, -1, 1, -1);
      tick();
      pulse_result(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   BW'($urandom_range(0, 15)), BW'($urandom_range(0, 15)), 1'b1);
    end
    check("ovw_drop_sat", drop_cnt, 8'd255);
    check("ovw_drop_model", drop_cnt, model_drop);
    check("ovw_id_final", res_frame_id, exp_id);
    res_ready = 1'b1;
    repeat (2) tick();
    check("ovw_res_q", exp_res_q.size(), 0);
    check("ovw_drained", res_valid, 0);

    // Back-to-back frames
    err0 = err_seen; pix0 = pix_seen;
    send_frame(NPIX, -1, -1, 1, -1);
    send_frame(NPIX, -1, 3, 1, -1);
    tick();
    pulse_result(4'd7, 4'd3, BW'(0), BW'(7), 1'b1);
    repeat (3) tick();
    check("b2b_pix_count", pix_seen - pix0, 2 * NPIX);
    check("b2b_no_err", err_seen - err0, 0);
    check("b2b_res_q", exp_res_q.size(), 0);

    // Enable dropped mid-frame, then sof ignored while disabled
    err0 = err_seen; pix0 = pix_seen;
    send_frame(NPIX, -1, -1, 1, 5);
    tick();
    pulse_result(4'd6, 4'd4, BW'(2), BW'(3), 1'b1);
    send_frame(NPIX, -1, -1, 0, -1);
    repeat (2) tick();
    check("en_pix_count", pix_seen - pix0, NPIX);
    check("en_no_err", err_seen - err0, 0);
    check("en_idle", busy, 0);
    enable = 1'b1;

    // Reset mid-STREAM
    send_frame(15, -1, -1, 1, -1);
    rst_n = 1'b0;
    exp_pix_q.delete();
    exp_id     = 8'hFF;
    model_drop = 0;
    #2;
    check("mrst_dec_rst_n", dec_rst_n, 0);
    check("mrst_dec_valid", dec_valid, 0);
    check("mrst_busy", busy, 0);
    check("mrst_frame_id", res_frame_id, 8'hFF);
    check("mrst_drop_cnt", drop_cnt, 0);
    check("mrst_res_valid", res_valid, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    pix0 = pix_seen;
    send_frame(NPIX, -1, -1, 1, -1);
    check("mrst_pending", busy, 1);
    tick();
    pulse_result(4'd6, 4'd3, BW'(2), BW'(5), 1'b1);
    check("mrst_res_valid_after", res_valid, 1);
    check("mrst_first_id", res_frame_id, 8'd0);
    repeat (3) tick();
    check("mrst_pix_count", pix_seen - pix0, NPIX);
    check("mrst_res_q", exp_res_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
